// File: rtl/follow_control_if.sv
// Buffer-read and image-memory-write bus between follow_control and its neighbours.
// The master modport is the controller side; the slave modport is the RAM/memory side.
interface follow_control_if #(
  parameter int PTR_W  = 7,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic                     buf_rd_en_o;
  logic [PTR_W-1:0]         buf_rd_addr_o;
  logic [ADDR_W+DATA_W-1:0] buf_rd_data_i;
  logic                     mem_wr_en_o;
  logic [ADDR_W-1:0]        mem_addr_o;
  logic [DATA_W-1:0]        mem_data_o;
  logic                     mem_ready_i;

  modport master (
    output buf_rd_en_o, buf_rd_addr_o, mem_wr_en_o, mem_addr_o, mem_data_o,
    input  buf_rd_data_i, mem_ready_i
  );

  modport slave (
    input  buf_rd_en_o, buf_rd_addr_o, mem_wr_en_o, mem_addr_o, mem_data_o,
    output buf_rd_data_i, mem_ready_i
  );
endinterface

// File: rtl/follow_control.sv
// Tail-side consumer of the uart_buffer circular queue: reads each pending entry and
// writes it to image memory, advancing the follow pointer only once the write is accepted.
module follow_control #(
  parameter int PTR_W  = 7,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [PTR_W-1:0]   lead_i,
  input  logic               hold_i,
  output logic [PTR_W-1:0]   follow_o,
  output logic               empty_o,
  output logic [PTR_W-1:0]   occupancy_o,
  output logic [CNT_W-1:0]   consumed_cnt_o,
  follow_control_if.master   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_WR} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    follow_q, follow_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic                buf_rd_en_q, buf_rd_en_d;
  logic [PTR_W-1:0]    follow_inc;
  logic                accept;

  assign follow_inc  = follow_q + 1'b1;
  assign accept      = (state_q == S_WR) && bus.mem_ready_i;
  assign empty_o     = (lead_i == follow_q);
  assign occupancy_o = lead_i - follow_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      follow_q    <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_wr_en_q <= 1'b0;
      buf_rd_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      follow_q    <= follow_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_wr_en_q <= mem_wr_en_d;
      buf_rd_en_q <= buf_rd_en_d;
    end
  end

  // lead_i is only looked at in IDLE and on the accepting edge of WR
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = (!empty_o && !hold_i) ? S_RD : S_IDLE;
      S_RD:    state_d = S_CAP;
      S_CAP:   state_d = S_WR;
      S_WR: begin
        if (bus.mem_ready_i)
          state_d = ((lead_i != follow_inc) && !hold_i) ? S_RD : S_IDLE;
        else
          state_d = S_WR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes follow the next state, so an unknown state recovers with both low
  always_comb begin
    buf_rd_en_d = (state_d == S_RD);
    mem_wr_en_d = (state_d == S_WR);
    follow_d    = accept ? follow_inc : follow_q;
    cnt_d       = accept ? cnt_q + 1'b1 : cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    if (state_q == S_CAP) begin
      mem_addr_d = bus.buf_rd_data_i[ADDR_W+DATA_W-1:DATA_W];
      mem_data_d = bus.buf_rd_data_i[DATA_W-1:0];
    end
  end

  assign follow_o          = follow_q;
  assign consumed_cnt_o    = cnt_q;
  assign bus.buf_rd_en_o   = buf_rd_en_q;
  assign bus.buf_rd_addr_o = follow_q;
  assign bus.mem_wr_en_o   = mem_wr_en_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.mem_data_o    = mem_data_q;

endmodule

// File: doc/follow_control.md
Name: follow_control

Overview:
- Consumer (tail) side of the 128-entry uart_buffer circular queue; sits directly downstream of the lead controller.
- Compares the lead pointer it receives with its own follow pointer and reads each pending entry from the buffer RAM.
- Splits each entry into an 11-bit pixel address and a 32-bit data word and issues one handshaked write per entry to image memory.
- Advances the follow pointer only after the memory write is accepted. The lead side therefore never overwrites an entry still in use.

Parameters:
- PTR_W, 7, buffer index width (128 entries, pointers wrap modulo 2^PTR_W).
- ADDR_W, 11, image-memory address width; occupies entry bits [ADDR_W+DATA_W-1:DATA_W].
- DATA_W, 32, image-memory data width; occupies entry bits [DATA_W-1:0].
- CNT_W, 16, width of the consumed-entry counter.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lead_i  in  PTR_W  head pointer from the lead controller (the next slot it will write).
- hold_i  in  1  when high, no new entry is started; an in-flight entry completes.
- follow_o  out  PTR_W  tail pointer (the next slot to consume); fed back to the lead controller.
- buf_rd_en_o  out  1  read strobe to the uart_buffer RAM.
- buf_rd_addr_o  out  PTR_W  RAM read address; always equals follow_o.
- buf_rd_data_i  in  ADDR_W+DATA_W  RAM read data; valid exactly one cycle after the strobe.
- mem_wr_en_o  out  1  write request to image memory.
- mem_addr_o  out  ADDR_W  write address, held stable while mem_wr_en_o is high.
- mem_data_o  out  DATA_W  write data, held stable while mem_wr_en_o is high.
- mem_ready_i  in  1  memory accepts the write on a rising edge where mem_wr_en_o and mem_ready_i are both high.
- empty_o  out  1  combinational; high when lead_i == follow_o.
- occupancy_o  out  PTR_W  combinational; (lead_i - follow_o) mod 2^PTR_W.
- consumed_cnt_o  out  CNT_W  number of accepted writes; wraps.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - follow_o = 0; buf_rd_en_o = 0; mem_wr_en_o = 0.
  - mem_addr_o = 0; mem_data_o = 0; consumed_cnt_o = 0.
  - The lead controller also resets its pointer to 0, so the queue comes up empty.
- All outputs are registered except empty_o, occupancy_o and buf_rd_addr_o.
- IDLE:
  - If !empty_o && !hold_i: next state RD and buf_rd_en_o <= 1.
  - Otherwise remain in IDLE.
- RD (buf_rd_en_o = 1 for exactly this one cycle): next state CAP and buf_rd_en_o <= 0.
- CAP:
  - mem_addr_o <= buf_rd_data_i[ADDR_W+DATA_W-1:DATA_W].
  - mem_data_o <= buf_rd_data_i[DATA_W-1:0].
  - mem_wr_en_o <= 1; next state WR.
- WR:
  - mem_wr_en_o, mem_addr_o and mem_data_o are held until mem_ready_i is sampled high.
  - On acceptance: follow_o <= follow_o + 1 (127 -> 0 wrap), consumed_cnt_o <= consumed_cnt_o + 1, mem_wr_en_o <= 0.
  - On acceptance, if another entry is pending (lead_i != follow_o + 1 mod 2^PTR_W) and !hold_i: go directly to RD with buf_rd_en_o <= 1.
  - On acceptance otherwise: go to IDLE.
- Throughput:
  - Back-to-back with mem_ready_i tied high: one entry per 3 cycles (RD, CAP, WR).
  - From IDLE: the first mem_wr_en_o assertion occurs 3 clock edges after lead_i first differs from follow_o.
- Invariant: follow_o never passes lead_i; an entry is consumed at most once.
- lead_i changing during RD, CAP or WR has no effect on the current entry. It is only evaluated in IDLE and at WR acceptance.
- Full queue (lead_i == follow_o - 1): no special handling; entries drain normally.
- Empty queue: buf_rd_en_o and mem_wr_en_o stay low indefinitely.
- hold_i asserted during RD, CAP or WR: the current entry completes, then the block parks in IDLE.
- Reset mid-transaction: an outstanding mem_wr_en_o drops immediately and the entry is discarded. The system resets the lead side at the same time.
- Illegal state encoding: recover to IDLE on the next edge with all strobes low.

Test Plan:
1. Single entry: after reset, drive lead_i 0 -> 1 with entry[0] = {11'h123, 32'hDEADBEEF} and mem_ready_i = 1. Required: buf_rd_en_o pulses for 1 cycle with addr 0; mem_wr_en_o is high for 1 cycle with mem_addr_o = 11'h123 and mem_data_o = 32'hDEADBEEF; then follow_o = 1, consumed_cnt_o = 1, empty_o = 1.
2. Burst: lead_i jumps 0 -> 5 with mem_ready_i = 1. Required: 5 writes at 3-cycle spacing, no IDLE cycle between them, addresses in slot order 0..4; follow_o ends at 5.
3. Backpressure: hold mem_ready_i = 0 for 10 cycles during WR. Required: mem_wr_en_o, mem_addr_o and mem_data_o are stable for all 10 cycles; follow_o is unchanged; exactly one acceptance on the cycle mem_ready_i rises.
4. Wrap: preset follow_o = 126 via 126 prior entries, then set lead_i = 2. Required: slots 126, 127, 0, 1 are consumed in order; follow_o = 2; occupancy_o is 4 before draining and 0 after.
5. hold_i and async reset: assert hold_i during CAP. Required: the write completes, then the block stays in IDLE with occupancy_o > 0. Then pull rst_n low while mem_wr_en_o = 1. Required: mem_wr_en_o = 0 with no clock edge; follow_o = 0; consumed_cnt_o = 0.
